// File: rtl/regfile_pkg.sv
// Shared constants and types for the multiport register file.
// Holds default geometry and the init sweep state encoding.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;

  typedef enum logic {
    IDLE,
    SWEEP
  } init_state_t;

endpackage

// File: rtl/regfile_multiport_if.sv
// Bus bundle for the multiport register file.
// master drives addresses/writes; slave returns read data.
interface regfile_multiport_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [ADDR_W-1:0]        dbg_addr;
  logic [DATA_W-1:0]        dbg_data;
  logic                     init_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    output rsv_en, rsv_addr, dbg_addr,
    input  rd_data, rd_pending, dbg_data, init_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  rsv_en, rsv_addr, dbg_addr,
    output rd_data, rd_pending, dbg_data, init_busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: reserve sets, committed write clears.
// Reads return the post-update bit, registered one cycle.
module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                busy_i,
  input  logic                                rsv_en_i,
  input  logic [$clog2(NUM_REGS)-1:0]         rsv_addr_i,
  input  logic                                clr_en_i,
  input  logic [$clog2(NUM_REGS)-1:0]         clr_addr_i,
  input  logic [NUM_RD*$clog2(NUM_REGS)-1:0]  rd_addr_i,
  output logic [NUM_RD-1:0]                   rd_pending_o
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [NUM_RD-1:0]   rdp_q, rdp_d;
  logic                rsv_ok;

  assign rsv_ok = rsv_en_i && !busy_i &&
                  !(ZERO_REG && rsv_addr_i == '0);

  // Next pending vector; reserve applied last so it wins a tie
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
    if (rsv_ok)   pend_d[rsv_addr_i] = 1'b1;
  end

  // Read ports see the updated vector, forced to 0 while sweeping
  always_comb begin
    rdp_d = '0;
    if (!busy_i) begin
      for (int k = 0; k < NUM_RD; k++)
        rdp_d[k] = pend_d[rd_addr_i[k*ADDR_W +: ADDR_W]];
    end
  end

  // Scoreboard and read-register state
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q <= '0;
      rdp_q  <= '0;
    end else begin
      pend_q <= pend_d;
      rdp_q  <= rdp_d;
    end
  end

  assign rd_pending_o = rdp_q;

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file with init sweep, bypass and scoreboard.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD
) (
  input logic                clock,
  input logic                reset,
  regfile_multiport_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0]        mem_q [NUM_REGS];
  init_state_t              state_q, state_d;
  logic [ADDR_W-1:0]        cnt_q, cnt_d;
  logic                     busy;
  logic                     sweep_we;
  logic                     wr_ok;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0]        dbg_q, dbg_d;

  assign busy  = (state_q == SWEEP);
  assign wr_ok = bus.wr_en && !busy &&
                 !(ZERO_REG && bus.wr_addr == '0);

  // Init FSM state register; reset restarts the sweep at 0
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Init FSM next state: one register per cycle, stop at the last
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_we = 1'b0;
    case (state_q)
      SWEEP: begin
        sweep_we = 1'b1;
        if (cnt_q == LAST) state_d = IDLE;
        else               cnt_d = cnt_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  // Storage: sweep fills reg[i]=i, else the write port commits
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (sweep_we)   mem_q[cnt_q]       <= DATA_W'(cnt_q);
      else if (wr_ok) mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] rd_word(
    input logic [ADDR_W-1:0] a
  );
    if (ZERO_REG && a == '0)
      return '0;
    else if (wr_ok && a == bus.wr_addr)
      return bus.wr_data;
    else
      return mem_q[a];
  endfunction

  // Read muxing with write bypass, zero while sweeping
  always_comb begin
    rd_data_d = '0;
    dbg_d     = '0;
    if (!busy) begin
      for (int k = 0; k < NUM_RD; k++)
        rd_data_d[k*DATA_W +: DATA_W] =
          rd_word(bus.rd_addr[k*ADDR_W +: ADDR_W]);
      dbg_d = rd_word(bus.dbg_addr);
    end
  end

  // Registered read outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= '0;
      dbg_q     <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      dbg_q     <= dbg_d;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clock        (clock),
    .reset        (reset),
    .busy_i       (busy),
    .rsv_en_i     (bus.rsv_en),
    .rsv_addr_i   (bus.rsv_addr),
    .clr_en_i     (wr_ok),
    .clr_addr_i   (bus.wr_addr),
    .rd_addr_i    (bus.rd_addr),
    .rd_pending_o (bus.rd_pending)
  );

  assign bus.rd_data   = rd_data_q;
  assign bus.dbg_data  = dbg_q;
  assign bus.init_busy = busy;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport (default and 4-port builds).
// Expectations for register 0 follow REGFILE_ZERO_REG_EN.
module tb_regfile_multiport;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  regfile_multiport_if #(
    .DATA_W(32), .NUM_REGS(32), .NUM_RD(2)
  ) bus_a ();

  regfile_multiport_if #(
    .DATA_W(16), .NUM_REGS(16), .NUM_RD(4)
  ) bus_b ();

  regfile_multiport #(
    .DATA_W(32), .NUM_REGS(32), .NUM_RD(2)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  regfile_multiport #(
    .DATA_W(16), .NUM_REGS(16), .NUM_RD(4)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    bus_a.rd_addr  = '0;
    bus_a.wr_en    = 1'b0;
    bus_a.wr_addr  = '0;
    bus_a.wr_data  = '0;
    bus_a.rsv_en   = 1'b0;
    bus_a.rsv_addr = '0;
    bus_a.dbg_addr = '0;
    bus_b.rd_addr  = '0;
    bus_b.wr_en    = 1'b0;
    bus_b.wr_addr  = '0;
    bus_b.wr_data  = '0;
    bus_b.rsv_en   = 1'b0;
    bus_b.rsv_addr = '0;
    bus_b.dbg_addr = '0;
  endtask

  task automatic test_reset;
    int n;
    int nb;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    tests++;
    if (bus_a.init_busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_busy got=%b exp=1", bus_a.init_busy);
    end
    tests++;
    if (bus_a.rd_data !== 64'h0) begin
      fails++;
      $display("FAIL reset_rd_data got=%h exp=0", bus_a.rd_data);
    end
    tests++;
    if (bus_a.rd_pending !== 2'b00) begin
      fails++;
      $display("FAIL reset_pending got=%b exp=00", bus_a.rd_pending);
    end
    tests++;
    if (bus_a.dbg_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_dbg got=%h exp=0", bus_a.dbg_data);
    end
    bus_a.rd_addr = {5'd31, 5'd5};
    bus_a.dbg_addr = 5'd31;
    reset = 1'b0;
    n = 0;
    nb = 0;
    while (bus_a.init_busy === 1'b1 && n < 100) begin
      tick();
      n++;
      if (bus_b.init_busy === 1'b0 && nb == 0) nb = n;
      if (n == 20) begin
        tests++;
        if (bus_a.rd_data !== 64'h0 || bus_a.dbg_data !== 32'h0) begin
          fails++;
          $display("FAIL sweep_reads_zero got=%h/%h exp=0",
                   bus_a.rd_data, bus_a.dbg_data);
        end
      end
    end
    tests++;
    if (n != 32) begin
      fails++;
      $display("FAIL sweep_len_a got=%0d exp=32", n);
    end
    tests++;
    if (nb != 16) begin
      fails++;
      $display("FAIL sweep_len_b got=%0d exp=16", nb);
    end
  endtask

  task automatic test_sweep_values;
    bus_a.rd_addr  = {5'd31, 5'd5};
    bus_a.dbg_addr = 5'd5;
    bus_b.rd_addr  = {4'd15, 4'd14, 4'd2, 4'd1};
    tick();
    tests++;
    if (bus_a.rd_data !== {32'd31, 32'd5}) begin
      fails++;
      $display("FAIL sweep_vals_a got=%h exp=%h",
               bus_a.rd_data, {32'd31, 32'd5});
    end
    tests++;
    if (bus_a.dbg_data !== 32'd5) begin
      fails++;
      $display("FAIL sweep_dbg got=%h exp=5", bus_a.dbg_data);
    end
    tests++;
    if (bus_b.rd_data !== {16'd15, 16'd14, 16'd2, 16'd1}) begin
      fails++;
      $display("FAIL sweep_vals_b got=%h exp=%h", bus_b.rd_data,
               {16'd15, 16'd14, 16'd2, 16'd1});
    end
    tests++;
    if (bus_a.rd_pending !== 2'b00) begin
      fails++;
      $display("FAIL sweep_pending got=%b exp=00", bus_a.rd_pending);
    end
  endtask

  task automatic test_bypass;
    bus_a.wr_en    = 1'b1;
    bus_a.wr_addr  = 5'd7;
    bus_a.wr_data  = 32'hDEADBEEF;
    bus_a.rd_addr  = {5'd6, 5'd7};
    bus_a.dbg_addr = 5'd7;
    tick();
    bus_a.wr_en = 1'b0;
    tests++;
    if (bus_a.rd_data !== {32'd6, 32'hDEADBEEF}) begin
      fails++;
      $display("FAIL bypass_rd got=%h exp=%h", bus_a.rd_data,
               {32'd6, 32'hDEADBEEF});
    end
    tests++;
    if (bus_a.dbg_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL bypass_dbg got=%h exp=deadbeef", bus_a.dbg_data);
    end
    tick();
    tests++;
    if (bus_a.rd_data[31:0] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL commit_rd got=%h exp=deadbeef",
               bus_a.rd_data[31:0]);
    end
  endtask

  task automatic test_scoreboard;
    bus_a.rsv_en   = 1'b1;
    bus_a.rsv_addr = 5'd3;
    bus_a.rd_addr  = {5'd0, 5'd0};
    tick();
    bus_a.rsv_en  = 1'b0;
    bus_a.rd_addr = {5'd4, 5'd3};
    tick();
    tests++;
    if (bus_a.rd_pending !== 2'b01) begin
      fails++;
      $display("FAIL rsv_pending got=%b exp=01", bus_a.rd_pending);
    end
    bus_a.rsv_en   = 1'b1;
    bus_a.rsv_addr = 5'd10;
    bus_a.rd_addr  = {5'd10, 5'd3};
    tick();
    bus_a.rsv_en = 1'b0;
    tests++;
    if (bus_a.rd_pending !== 2'b11) begin
      fails++;
      $display("FAIL rsv_bypass got=%b exp=11", bus_a.rd_pending);
    end
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = 5'd3;
    bus_a.wr_data = 32'h33;
    tick();
    bus_a.wr_en = 1'b0;
    tests++;
    if (bus_a.rd_pending !== 2'b10) begin
      fails++;
      $display("FAIL wr_clears got=%b exp=10", bus_a.rd_pending);
    end
    tests++;
    if (bus_a.rd_data[31:0] !== 32'h33) begin
      fails++;
      $display("FAIL wr_clear_data got=%h exp=33", bus_a.rd_data[31:0]);
    end
    bus_a.rsv_en   = 1'b1;
    bus_a.rsv_addr = 5'd9;
    bus_a.wr_en    = 1'b1;
    bus_a.wr_addr  = 5'd9;
    bus_a.wr_data  = 32'h99;
    bus_a.rd_addr  = {5'd3, 5'd9};
    tick();
    bus_a.rsv_en = 1'b0;
    bus_a.wr_en  = 1'b0;
    tests++;
    if (bus_a.rd_pending !== 2'b01 || bus_a.rd_data[31:0] !== 32'h99) begin
      fails++;
      $display("FAIL rsv_wins got=%b/%h exp=01/99",
               bus_a.rd_pending, bus_a.rd_data[31:0]);
    end
    tick();
    tests++;
    if (bus_a.rd_pending !== 2'b01) begin
      fails++;
      $display("FAIL rsv_wins_held got=%b exp=01", bus_a.rd_pending);
    end
  endtask

  task automatic test_back_to_back;
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = 5'd20;
    bus_a.wr_data = 32'hA0A0A0A0;
    bus_a.rd_addr = {5'd0, 5'd20};
    tick();
    tests++;
    if (bus_a.rd_data[31:0] !== 32'hA0A0A0A0) begin
      fails++;
      $display("FAIL b2b_1 got=%h exp=a0a0a0a0", bus_a.rd_data[31:0]);
    end
    bus_a.wr_addr = 5'd21;
    bus_a.wr_data = 32'hB1B1B1B1;
    bus_a.rd_addr = {5'd21, 5'd20};
    tick();
    tests++;
    if (bus_a.rd_data !== {32'hB1B1B1B1, 32'hA0A0A0A0}) begin
      fails++;
      $display("FAIL b2b_2 got=%h exp=b1b1b1b1a0a0a0a0", bus_a.rd_data);
    end
    bus_a.wr_addr = 5'd20;
    bus_a.wr_data = 32'hC2C2C2C2;
    tick();
    bus_a.wr_en = 1'b0;
    tests++;
    if (bus_a.rd_data !== {32'hB1B1B1B1, 32'hC2C2C2C2}) begin
      fails++;
      $display("FAIL b2b_3 got=%h exp=b1b1b1b1c2c2c2c2", bus_a.rd_data);
    end
  endtask

  task automatic test_sweep_restart;
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_a.rd_addr  = {5'd31, 5'd7};
    bus_a.dbg_addr = 5'd31;
    bus_a.wr_en    = 1'b1;
    bus_a.wr_addr  = 5'd4;
    bus_a.wr_data  = 32'h1234;
    bus_a.rsv_en   = 1'b1;
    bus_a.rsv_addr = 5'd7;
    for (int i = 0; i < 10; i++) tick();
    tests++;
    if (bus_a.rd_data !== 64'h0 || bus_a.dbg_data !== 32'h0 ||
        bus_a.rd_pending !== 2'b00) begin
      fails++;
      $display("FAIL sweep_mid_zero got=%h/%h/%b exp=0/0/00",
               bus_a.rd_data, bus_a.dbg_data, bus_a.rd_pending);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    while (bus_a.init_busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    bus_a.wr_en  = 1'b0;
    bus_a.rsv_en = 1'b0;
    tests++;
    if (n != 32) begin
      fails++;
      $display("FAIL restart_len got=%0d exp=32", n);
    end
    bus_a.rd_addr  = {5'd31, 5'd4};
    bus_a.dbg_addr = 5'd4;
    bus_a.rsv_en   = 1'b0;
    tick();
    tests++;
    if (bus_a.rd_data !== {32'd31, 32'd4} || bus_a.dbg_data !== 32'd4) begin
      fails++;
      $display("FAIL sweep_ignores_wr got=%h/%h exp=%h/4",
               bus_a.rd_data, bus_a.dbg_data, {32'd31, 32'd4});
    end
    bus_a.rd_addr = {5'd7, 5'd4};
    tick();
    tests++;
    if (bus_a.rd_pending !== 2'b00) begin
      fails++;
      $display("FAIL sweep_ignores_rsv got=%b exp=00", bus_a.rd_pending);
    end
  endtask

  task automatic test_zero_reg;
    logic [31:0] exp_d;
    logic [1:0]  exp_p;
`ifdef REGFILE_ZERO_REG_EN
    exp_d = 32'h0;
    exp_p = 2'b00;
`else
    exp_d = 32'hFFFFFFFF;
    exp_p = 2'b11;
`endif
    bus_a.wr_en    = 1'b1;
    bus_a.wr_addr  = 5'd0;
    bus_a.wr_data  = 32'hFFFFFFFF;
    bus_a.rsv_en   = 1'b1;
    bus_a.rsv_addr = 5'd0;
    bus_a.rd_addr  = {5'd0, 5'd0};
    bus_a.dbg_addr = 5'd0;
    tick();
    bus_a.wr_en  = 1'b0;
    bus_a.rsv_en = 1'b0;
    tests++;
    if (bus_a.rd_data !== {exp_d, exp_d} || bus_a.dbg_data !== exp_d) begin
      fails++;
      $display("FAIL zero_reg_byp got=%h/%h exp=%h",
               bus_a.rd_data, bus_a.dbg_data, exp_d);
    end
    tests++;
    if (bus_a.rd_pending !== exp_p) begin
      fails++;
      $display("FAIL zero_reg_pend got=%b exp=%b",
               bus_a.rd_pending, exp_p);
    end
    tick();
    tests++;
    if (bus_a.rd_data !== {exp_d, exp_d} || bus_a.dbg_data !== exp_d) begin
      fails++;
      $display("FAIL zero_reg_store got=%h/%h exp=%h",
               bus_a.rd_data, bus_a.dbg_data, exp_d);
    end
  endtask

  initial begin
    test_reset();
    test_sweep_values();
    test_bypass();
    test_scoreboard();
    test_back_to_back();
    test_sweep_restart();
    test_zero_reg();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, register count (power of two, >=4); ADDR_W = clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have: clock  in  1  sole clock, all logic posedge.
REQ-005 SHALL have: reset  in  1  synchronous, active-high.
REQ-006 SHALL have: rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-007 SHALL have: rd_data  out  NUM_RD*DATA_W  read data, same packing.
REQ-008 SHALL have: rd_pending  out  NUM_RD  scoreboard bit of each read address.
REQ-009 SHALL have: wr_en, wr_addr, wr_data  in  1/ADDR_W/DATA_W  write port.
REQ-010 SHALL have: rsv_en, rsv_addr  in  1/ADDR_W  scoreboard reserve port.
REQ-011 SHALL have: dbg_addr  in  ADDR_W; dbg_data  out  DATA_W  debug read port.
REQ-012 SHALL have: init_busy  out  1  initialisation sweep in progress.

Function
REQ-013 Reads SHALL be synchronous: rd_data/rd_pending/dbg_data update on the posedge after the address is presented (latency 1).
REQ-014 Write SHALL commit at posedge when wr_en=1 and init_busy=0.
REQ-015 Same-cycle write/read to the same address SHALL bypass: rd_data/dbg_data return wr_data, not the old value.
REQ-016 Scoreboard: rsv_en sets pending[rsv_addr]; committed write clears pending[wr_addr].
REQ-017 rsv_addr==wr_addr in the same cycle SHALL leave the bit set (reserve wins).
REQ-018 rd_pending SHALL reflect the post-update scoreboard state (bypassed like data).
REQ-019 Init FSM states IDLE, SWEEP: reset forces SWEEP with counter=0; each SWEEP cycle writes register[counter]=counter (zero-extended) and increments.
REQ-020 SWEEP->IDLE on the cycle register NUM_REGS-1 is written; init_busy=1 exactly in SWEEP, deasserting NUM_REGS cycles after reset release.
REQ-021 During SWEEP, wr_en and rsv_en SHALL be ignored; rd_data, dbg_data, rd_pending SHALL read 0.
REQ-022 Address wrap: counter SHALL not wrap past NUM_REGS-1; out-of-range is impossible by width.

Reset
REQ-023 On reset: rd_data=0, rd_pending=0, dbg_data=0, all pending bits=0, init_busy=1, counter=0.
REQ-024 Reset asserted mid-SWEEP SHALL restart the sweep from register 0.
REQ-025 Register array contents SHALL be defined only by the sweep, not by reset directly.

Configuration
REQ-026 Macro REGFILE_ZERO_REG_EN defined: register 0 reads 0 on every port, writes/reserves to address 0 are dropped, pending[0] stays 0, sweep writes 0.
REQ-027 Macro undefined: register 0 behaves as any other register (sweep value 0, writable, reservable).

Structure
REQ-028 Shared package regfile_pkg SHALL hold default DATA_W/NUM_REGS/NUM_RD constants and the init state enum (IDLE, SWEEP).
REQ-029 Sub-module regfile_scoreboard SHALL own the pending-bit vector, reserve/clear logic and its read muxing; storage, bypass and init FSM stay in the top.

Verification
REQ-030 Reset 1 cycle then release -> init_busy high for exactly 32 cycles; then reading addr 5 and 31 returns 5 and 31.
REQ-031 wr_en=1, wr_addr=7, wr_data=0xDEADBEEF with rd_addr port0=7 same cycle -> next cycle rd_data port0=0xDEADBEEF (bypass).
REQ-032 rsv_en addr 3, next cycle read addr 3 -> rd_pending=1; write addr 3 -> read returns pending=0; simultaneous rsv and wr to addr 9 -> pending=1.
REQ-033 Reset asserted at sweep cycle 10 -> init_busy stays high 32 further cycles; wr_en during sweep to addr 4 with 0x1234 -> addr 4 reads 4 afterwards.
REQ-034 With REGFILE_ZERO_REG_EN: write 0xFFFFFFFF to addr 0 -> all ports read 0 and pending 0; without macro -> reads 0xFFFFFFFF.
REQ-035 NUM_RD=4, DATA_W=16, NUM_REGS=16 build: sweep takes 16 cycles; four ports read addrs 1,2,14,15 simultaneously -> 1,2,14,15.
